sat_addsub_pipe: RTL

SAT_ADDSUB_PIPE -- requirements
Module: sat_addsub_pipe

---
 rtl/sat_pkg.sv | 26 ++
 rtl/sat_lane.sv | 48 ++++
 rtl/sat_addsub_pipe.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
// Module : sat_pkg
// Brief  : Operation encoding and saturation bound helpers for sat_addsub_pipe
// Rev    : 1.0
// ============================================================================
package sat_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PADD = 2'b10,
        OP_ACC  = 2'b11
    } op_e;

    // Bounds are returned sign-extended to 64 bits; callers keep the low w bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_lane.sv
`default_nettype none
// ============================================================================
// Module : sat_lane
// Brief  : LANE_W-bit carry-lookahead adder slice with signed-overflow output
// Rev    : 1.0
// ============================================================================
module sat_lane #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic              cin,
    output logic [LANE_W-1:0] sum,
    output logic              cout,
    output logic              o_ovf
);
    import sat_pkg::*;

    logic [LANE_W-1:0] w_g;
    logic [LANE_W-1:0] w_p;
    logic [LANE_W:0]   w_c;
    logic              w_cc;
    logic              w_pp;

    always_comb begin
        w_g  = i_a & i_b;
        w_p  = i_a ^ i_b;
        w_c  = '0;
        w_cc = 1'b0;
        w_pp = 1'b1;
        w_c[0] = cin;
        // Each carry is the flat OR of generate terms gated by downstream propagates.
        for (int i = 0; i < LANE_W; i++) begin
            w_cc = 1'b0;
            w_pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_cc = w_cc | (w_pp & w_g[j]);
                w_pp = w_pp & w_p[j];
            end
            w_c[i+1] = w_cc | (w_pp & cin);
        end
        sum   = w_p ^ w_c[LANE_W-1:0];
        cout  = w_c[LANE_W];
        o_ovf = (i_a[LANE_W-1] == i_b[LANE_W-1]) && (sum[LANE_W-1] != i_a[LANE_W-1]);
    end

endmodule
`default_nettype wire

// File: rtl/sat_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module : sat_addsub_pipe
// Brief  : Two-stage elastic saturating add/sub/packed-add/accumulate unit
// Rev    : 1.0
// ============================================================================
module sat_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);
    import sat_pkg::*;

    localparam int                c_n_lanes   = WIDTH / LANE_W;
    localparam logic [63:0]       c_max_64    = sat_max(WIDTH);
    localparam logic [63:0]       c_min_64    = sat_min(WIDTH);
    localparam logic [63:0]       c_lmax_64   = sat_max(LANE_W);
    localparam logic [63:0]       c_lmin_64   = sat_min(LANE_W);
    localparam logic [WIDTH-1:0]  c_max       = c_max_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0]  c_min       = c_min_64[WIDTH-1:0];
    localparam logic [LANE_W-1:0] c_lane_max  = c_lmax_64[LANE_W-1:0];
    localparam logic [LANE_W-1:0] c_lane_min  = c_lmin_64[LANE_W-1:0];

    // On overflow the wrapped sum has the wrong sign, so its MSB picks the rail.
    function automatic logic [WIDTH-1:0] sat_full(input logic [WIDTH-1:0] s, input logic ovf);
        return ovf ? (s[WIDTH-1] ? c_max : c_min) : s;
    endfunction

    function automatic logic [LANE_W-1:0] sat_lane_val(input logic [LANE_W-1:0] s, input logic ovf);
        return ovf ? (s[LANE_W-1] ? c_lane_max : c_lane_min) : s;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    op_e                  s1_op_q, s1_op_d;
    logic [WIDTH-1:0]     s1_sum_q, s1_sum_d;
    logic [c_n_lanes-1:0] s1_ovf_q, s1_ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 flag_z_q, flag_z_d;
    logic                 flag_v_q, flag_v_d;
    logic                 flag_n_q, flag_n_d;
    logic [WIDTH-1:0]     acc_q, acc_d;

    op_e                  w_op;
    logic [WIDTH-1:0]     w_x;
    logic [WIDTH-1:0]     w_y;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_acc_base;
    logic [c_n_lanes-1:0] w_lane_ovf;
    logic                 w_accept;
    logic                 w_s2_load;
    logic [WIDTH-1:0]     w_s2_result;
    logic                 w_s2_ovf;
    logic                 w_unused_cout;

    assign in_ready  = !s1_valid_q || !out_valid_q || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_s2_load = s1_valid_q && (!out_valid_q || out_ready);

    always_comb begin
        w_op       = op_e'(op);
        w_acc_base = acc_clr ? '0 : acc_q;
        w_x        = a;
        w_y        = b;
        case (w_op)
            OP_SUB: w_y = ~b;
            OP_ACC: begin
                w_x = w_acc_base;
                w_y = a;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < c_n_lanes; gi++) begin : g_lane
        logic w_lane_cin;
        logic w_lane_cout;
        if (gi == 0) begin : g_first
            assign w_lane_cin = (w_op == OP_SUB);
        end else begin : g_chain
            assign w_lane_cin = (w_op == OP_PADD) ? 1'b0 : g_lane[gi-1].w_lane_cout;
        end
        sat_lane #(.LANE_W(LANE_W)) u_lane (
            .i_a   (w_x[gi*LANE_W +: LANE_W]),
            .i_b   (w_y[gi*LANE_W +: LANE_W]),
            .cin   (w_lane_cin),
            .sum   (w_sum[gi*LANE_W +: LANE_W]),
            .cout  (w_lane_cout),
            .o_ovf (w_lane_ovf[gi])
        );
    end

    assign w_unused_cout = g_lane[c_n_lanes-1].w_lane_cout;

    always_comb begin
        w_s2_result = sat_full(s1_sum_q, s1_ovf_q[c_n_lanes-1]);
        w_s2_ovf    = s1_ovf_q[c_n_lanes-1];
        if (s1_op_q == OP_PADD) begin
            w_s2_ovf = |s1_ovf_q;
            for (int i = 0; i < c_n_lanes; i++) begin
                w_s2_result[i*LANE_W +: LANE_W] =
                    sat_lane_val(s1_sum_q[i*LANE_W +: LANE_W], s1_ovf_q[i]);
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_sum_d    = s1_sum_q;
        s1_ovf_d    = s1_ovf_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_v_d    = flag_v_q;
        flag_n_d    = flag_n_q;
        acc_d       = acc_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d  = w_op;
                s1_sum_d = w_sum;
                s1_ovf_d = w_lane_ovf;
            end
        end

        // The accumulator must update in the accept cycle so ACC beats chain.
        if (acc_clr) begin
            acc_d = '0;
        end
        if (w_accept && (w_op == OP_ACC)) begin
            acc_d = sat_full(w_sum, w_lane_ovf[c_n_lanes-1]);
        end

        if (w_s2_load) begin
            out_valid_d = 1'b1;
            result_d    = w_s2_result;
            flag_z_d    = (w_s2_result == '0);
            flag_v_d    = w_s2_ovf;
            flag_n_d    = w_s2_result[WIDTH-1];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_sum_q    <= '0;
            s1_ovf_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_z_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_sum_q    <= s1_sum_d;
            s1_ovf_q    <= s1_ovf_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_z_q    <= flag_z_d;
            flag_v_q    <= flag_v_d;
            flag_n_q    <= flag_n_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_v    = flag_v_q;
    assign flag_n    = flag_n_q;

endmodule
`default_nettype wire
